// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART receiver with 16x oversampling and majority vote
//
// Turns the asynchronous serial line into one byte plus a one-cycle strobe per
// frame, LSB first. Each bit is split into 16 baud ticks. The synchronised line is
// sampled on ticks 6..12 and a 7-sample majority vote decides the bit value.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous, active-high reset
//   baud_set   0:9600 1:19200 2:38400 3:57600 4..7:115200, latched at start detection
//   uart_rx    asynchronous serial input, idle high
//   rx_data    last correctly framed byte, held until the next good frame
//   rx_done    one-cycle pulse, rx_data valid in the same cycle
//   frame_err  one-cycle pulse, stop bit voted low
//   rx_busy    high from start detection until the FSM returns to IDLE
`timescale 1ns/1ps

module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int DIV_9600   = CLK_FREQ / (9600 * 16);
  localparam int DIV_19200  = CLK_FREQ / (19200 * 16);
  localparam int DIV_38400  = CLK_FREQ / (38400 * 16);
  localparam int DIV_57600  = CLK_FREQ / (57600 * 16);
  localparam int DIV_115200 = CLK_FREQ / (115200 * 16);
  // The slowest rate has the largest divisor, so it sets the counter width.
  localparam int DW = $clog2(DIV_9600 + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_s1, rx_s2, rx_prev;
  logic          falling;
  logic          start_det;
  logic [2:0]    baud_q;
  logic [DW-1:0] div_cnt, div_lim;
  logic          tick;
  logic [3:0]    tick_cnt;
  logic [2:0]    sum_q, sum_next;
  logic          in_window, decide, end_bit, vote;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          shift_en, done_d, err_d;

  // Two flops of synchronisation plus one delay stage for edge detection. All
  // reset to 0, so a line that is already low at reset release never looks like
  // a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1   <= 1'b0;
      rx_s2   <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign falling   = rx_prev & ~rx_s2;
  assign start_det = (state_q == IDLE) && falling;

  always_comb begin
    div_lim = DW'(DIV_115200 - 1);
    case (baud_q)
      3'd0:    div_lim = DW'(DIV_9600 - 1);
      3'd1:    div_lim = DW'(DIV_19200 - 1);
      3'd2:    div_lim = DW'(DIV_38400 - 1);
      3'd3:    div_lim = DW'(DIV_57600 - 1);
      default: div_lim = DW'(DIV_115200 - 1);
    endcase
  end

  assign tick      = (div_cnt == div_lim);
  assign in_window = tick && (tick_cnt >= 4'd6) && (tick_cnt <= 4'd12);
  assign decide    = tick && (tick_cnt == 4'd12);
  assign end_bit   = tick && (tick_cnt == 4'd15);
  // At tick 12 the seventh sample is still on the line, so the vote uses the
  // running sum including the current sample.
  assign sum_next  = sum_q + {2'b00, rx_s2};
  assign vote      = (sum_next >= 3'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (falling) state_d = START;
      end
      START: begin
        if (decide && vote) state_d = IDLE;   // start bit voted high: false start
        else if (end_bit)   state_d = DATA;
      end
      DATA: begin
        if (decide) shift_en = 1'b1;
        if (end_bit && (bit_idx == 3'd7)) state_d = STOP;
      end
      STOP: begin
        // Leave at tick 12 rather than 15 so a back-to-back start edge is seen.
        if (decide) begin
          state_d = IDLE;
          if (vote) done_d = 1'b1;
          else      err_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q    <= 3'd0;
      div_cnt   <= '0;
      tick_cnt  <= 4'd0;
      sum_q     <= 3'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b0;
    end else begin
      rx_done   <= done_d;
      frame_err <= err_d;
      rx_busy   <= (state_d != IDLE);
      if (done_d) rx_data <= shreg;

      if (start_det) begin
        // Restart the divider on the edge so tick phases line up with the frame.
        baud_q   <= baud_set;
        div_cnt  <= '0;
        tick_cnt <= 4'd0;
        sum_q    <= 3'd0;
        bit_idx  <= 3'd0;
      end else begin
        if (tick) begin
          div_cnt  <= '0;
          tick_cnt <= tick_cnt + 4'd1;
          if (end_bit)        sum_q <= 3'd0;
          else if (in_window) sum_q <= sum_next;
        end else begin
          div_cnt <= div_cnt + DW'(1);
        end
        if (shift_en) shreg <= {vote, shreg[7:1]};
        if ((state_q == DATA) && end_bit) bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb/tb_uart_byte_rx.sv - self-checking bench for uart_byte_rx
`timescale 1ns/1ps

module tb_uart_byte_rx;

  // 18.432 MHz divides every supported baud rate exactly and keeps the run short.
  localparam int      CLK_FREQ = 18_432_000;
  localparam realtime HALF     = 1.0e9 / CLK_FREQ / 2.0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_set = 3'd4;
  logic       uart_rx = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [7:0] done_q[$];

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk(clk),
    .reset(reset),
    .baud_set(baud_set),
    .uart_rx(uart_rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .rx_busy(rx_busy)
  );

  always #(HALF) clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      done_q.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
  end

  typedef struct {
    logic [2:0] baud;
    logic [7:0] data;
    logic       stop;
    realtime    bit_ns;
    logic [2:0] mid_baud;
    realtime    glitch_ns;
    realtime    spike_ns;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[6];
  vec_t       v;
  logic [7:0] b2b[8];
  int         base_done, base_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input realtime bit_ns,
                            input logic [2:0] mid_baud, input realtime spike_ns);
    uart_rx = 1'b0;
    #(bit_ns);
    baud_set = mid_baud;
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == 1 && spike_ns > 0.0) begin
        #(bit_ns / 2.0);
        uart_rx = ~b[i];
        #(spike_ns);
        uart_rx = b[i];
        #(bit_ns / 2.0 - spike_ns);
      end else begin
        #(bit_ns);
      end
    end
    uart_rx = stop;
    #(bit_ns);
    uart_rx = 1'b1;
  endtask

  initial begin
    vecs[0] = '{3'd4, 8'h55, 1'b1, 8680.0,   3'd4, 0.0,    0.0,  1, 0, 8'h55};
    vecs[1] = '{3'd4, 8'h12, 1'b1, 8680.0,   3'd4, 2000.0, 0.0,  1, 0, 8'h12};
    vecs[2] = '{3'd4, 8'hF1, 1'b0, 8680.0,   3'd4, 0.0,    0.0,  0, 1, 8'h12};
    vecs[3] = '{3'd0, 8'hA5, 1'b1, 104166.0, 3'd0, 0.0,    40.0, 1, 0, 8'hA5};
    vecs[4] = '{3'd4, 8'h9A, 1'b1, 8420.0,   3'd0, 0.0,    0.0,  1, 0, 8'h9A};
    vecs[5] = '{3'd7, 8'h9A, 1'b1, 8940.0,   3'd7, 0.0,    0.0,  1, 0, 8'h9A};
    b2b = '{8'h55, 8'hA5, 8'h00, 8'h00, 8'hC3, 8'h50, 8'hAA, 8'hF0};

    // Reset with the line held low: release must not be taken as a start.
    #5 reset = 1'b1;
    #10;
    check("reset_rx_data", rx_data, 0);
    check("reset_rx_done", rx_done, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_rx_busy", rx_busy, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("low_at_release_busy", rx_busy, 0);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_busy", rx_busy, 0);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      baud_set  = v.baud;
      base_done = done_cnt;
      base_err  = err_cnt;
      if (v.glitch_ns > 0.0) begin
        uart_rx = 1'b0;
        #(v.glitch_ns);
        uart_rx = 1'b1;
        #(v.bit_ns);
        @(negedge clk);
        check($sformatf("v%0d_glitch_busy", i), rx_busy, 0);
        check($sformatf("v%0d_glitch_pulses", i), done_cnt + err_cnt - base_done - base_err, 0);
      end
      send_frame(v.data, v.stop, v.bit_ns, v.mid_baud, v.spike_ns);
      #(v.bit_ns);
      @(negedge clk);
      check($sformatf("v%0d_done_count", i), done_cnt - base_done, v.exp_done);
      check($sformatf("v%0d_err_count", i), err_cnt - base_err, v.exp_err);
      check($sformatf("v%0d_rx_data", i), rx_data, v.exp_data);
      check($sformatf("v%0d_busy_after", i), rx_busy, 0);
    end

    // Eight frames with no idle time between them.
    baud_set = 3'd4;
    done_q.delete();
    base_err = err_cnt;
    for (int i = 0; i < 8; i++) send_frame(b2b[i], 1'b1, 8680.0, 3'd4, 0.0);
    #(8680.0);
    @(negedge clk);
    check("b2b_count", done_q.size(), 8);
    check("b2b_err", err_cnt - base_err, 0);
    for (int i = 0; i < 8; i++) begin
      if (i < done_q.size()) check($sformatf("b2b_byte%0d", i), done_q[i], b2b[i]);
      else check($sformatf("b2b_byte%0d_missing", i), 1, 0);
    end

    // Reset in the middle of bit 3 of 0x78, held until the line is idle again.
    base_done = done_cnt;
    base_err  = err_cnt;
    fork
      send_frame(8'h78, 1'b1, 8680.0, 3'd4, 0.0);
      begin
        #(8680.0 * 4.5);
        @(negedge clk);
        check("busy_before_reset", rx_busy, 1);
        #3.0 reset = 1'b1;
        #1;
        check("midframe_rst_rx_data", rx_data, 0);
        check("midframe_rst_rx_done", rx_done, 0);
        check("midframe_rst_frame_err", frame_err, 0);
        check("midframe_rst_rx_busy", rx_busy, 0);
      end
    join
    #(8680.0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h34, 1'b1, 8680.0, 3'd4, 0.0);
    #(8680.0);
    @(negedge clk);
    check("after_rst_done_count", done_cnt - base_done, 1);
    check("after_rst_err_count", err_cnt - base_err, 0);
    check("after_rst_rx_data", rx_data, 8'h34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
